warehouse_table: RTL and testbench
==================================

WAREHOUSE_TABLE -- requirements
Module: warehouse_table

Interface
REQ-001 SHALL have parameter N_SLOTS, default 24: number of table entries, range 2..64.
REQ-002 SHALL have parameter ID_W, default 6: slot-ID width.
REQ-003 SHALL have parameter X_W, default 9: X coordinate width.
REQ-004 SHALL have parameter Y_W, default 8: Y coordinate width.
REQ-005 SHALL have parameter DIR_W, default 12: direction width.
REQ-006 SHALL have localparam IDX_W = clog2(N_SLOTS).
REQ-007 SHALL have port sys_clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port req_valid, input, 1: lookup request.
REQ-010 SHALL have port req_id, input, ID_W: slot ID to look up.
REQ-011 SHALL have port req_ready, output, 1: block can accept a request.
REQ-012 SHALL have port wr_en, input, 1: table write strobe.
REQ-013 SHALL have port wr_idx, input, IDX_W: entry index to write.
REQ-014 SHALL have port wr_id / wr_x / wr_y / wr_dir, inputs, ID_W / X_W / Y_W / DIR_W: entry contents.
REQ-015 SHALL have port rsp_valid, output, 1: one-cycle result pulse.
REQ-016 SHALL have port rsp_hit, output, 1: 1 = ID found, 0 = miss.
REQ-017 SHALL have port x_out / y_out / dir_out, outputs, X_W / Y_W / DIR_W: coordinates of the matched entry.
REQ-018 SHALL have port busy, output, 1: lookup in progress.

Function
REQ-019 SHALL hold N_SLOTS entries, each {vld, id, x, y, dir}, in flops.
REQ-020 SHALL write the entry on any cycle with wr_en=1 and wr_idx<N_SLOTS: entry[wr_idx] <= {1, wr_id, wr_x, wr_y, wr_dir}, visible from the next cycle.
REQ-021 SHALL ignore writes with wr_idx>=N_SLOTS without side effect.
REQ-022 SHALL implement FSM states IDLE, SCAN, RESP.
REQ-023 SHALL drive req_ready=1 only in IDLE; busy = !req_ready.
REQ-024 IDLE: on req_valid=1 the block SHALL latch req_id, clear scan index k to 0, and go to SCAN; req_valid in SCAN/RESP SHALL be ignored (not queued).
REQ-025 SCAN: each cycle the block SHALL compare entry[k] (vld=1 and id==latched ID); on a hit it SHALL register x/y/dir and set hit=1, then go to RESP.
REQ-026 SCAN: on no hit with k<N_SLOTS-1, the block SHALL set k<=k+1; on no hit at k=N_SLOTS-1, it SHALL set hit=0, zero x/y/dir, and go to RESP.
REQ-027 RESP: the block SHALL assert rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-028 Latency: for a request accepted at edge T with first hit at index k, rsp_valid SHALL be high in cycle T+k+2; a miss SHALL respond in cycle T+N_SLOTS+1.
REQ-029 Duplicate IDs: the lowest matching index SHALL win.
REQ-030 Entries with vld=0 SHALL never match.
REQ-031 A write to the entry currently being compared SHALL not affect that compare (old contents used); writes to higher indices SHALL be seen by the ongoing scan.
REQ-032 rsp_hit/x_out/y_out/dir_out SHALL hold their last values until the next RESP.
REQ-033 A new request SHALL be accepted in the cycle after RESP at the earliest.

Reset
REQ-034 sys_rst_n=0 SHALL, asynchronously, set FSM=IDLE, k=0, all entry vld=0, rsp_valid=0, rsp_hit=0, x_out=y_out=dir_out=0, req_ready=1, busy=0.
REQ-035 Entry id/x/y/dir fields SHALL reset to 0.
REQ-036 Reset mid-SCAN SHALL abort the lookup with no rsp_valid pulse.

Verification
REQ-037 Write idx0 {id=1,x=255,y=145}, request id=1 -> rsp_valid at T+2, rsp_hit=1, x_out=255, y_out=145.
REQ-038 Fill 24 entries with id=i+1, request id=24 -> response at T+25, hit=1, coordinates of idx23.
REQ-039 Request id=30 (absent) -> response at T+25, rsp_hit=0, x_out=y_out=dir_out=0.
REQ-040 id=5 written at idx2 and idx7, request 5 -> hit returns idx2 data at T+4.
REQ-041 Request id=9 (at idx8); write idx3 id=9 during scan at k=5; write wr_idx=31 -> idx8 data returned, out-of-range write has no effect.
REQ-042 Assert reset at k=10 -> no rsp_valid, all entries invalid, a following request misses.

Source files
------------

// File: rtl/warehouse_table.sv
`default_nettype none
// ============================================================================
// Module   : warehouse_table
// Brief    : Flop-based table of {vld, id, x, y, dir} entries. A request
//            triggers a sequential scan from index 0 upward. The lowest
//            valid entry whose id matches wins. The block returns a
//            one-cycle response carrying the coordinates, or zeros on a miss.
// Revision : 1.0 - initial release
// ============================================================================
module warehouse_table #(
    parameter  int N_SLOTS = 24,
    parameter  int ID_W    = 6,
    parameter  int X_W     = 9,
    parameter  int Y_W     = 8,
    parameter  int DIR_W   = 12,
    localparam int IDX_W   = $clog2(N_SLOTS)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req_valid,
    input  logic [ID_W-1:0]  req_id,
    output logic             req_ready,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ID_W-1:0]  wr_id,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [DIR_W-1:0] wr_dir,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [DIR_W-1:0] dir_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // One extra bit so that N_SLOTS itself is representable for the range check
    localparam logic [IDX_W:0]   c_n_slots = (IDX_W+1)'(N_SLOTS);
    localparam logic [IDX_W-1:0] c_last    = IDX_W'(N_SLOTS - 1);

    // Table storage
    logic             r_vld [N_SLOTS];
    logic [ID_W-1:0]  r_id  [N_SLOTS];
    logic [X_W-1:0]   r_x   [N_SLOTS];
    logic [Y_W-1:0]   r_y   [N_SLOTS];
    logic [DIR_W-1:0] r_dir [N_SLOTS];

    // Scan control and result registers
    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_k;
    logic [ID_W-1:0]  r_req_id;
    logic             r_hit;
    logic [X_W-1:0]   r_x_out;
    logic [Y_W-1:0]   r_y_out;
    logic [DIR_W-1:0] r_dir_out;

    logic             w_wr_ok;
    logic             w_hit;
    logic             w_last;

    // Out-of-range indices are dropped here, so they never touch the array
    assign w_wr_ok = wr_en && ({1'b0, wr_idx} < c_n_slots);

    // The compare reads registered contents, so a same-cycle write to entry k
    // only becomes visible after this compare
    assign w_hit   = r_vld[r_k] && (r_id[r_k] == r_req_id);
    assign w_last  = (r_k == c_last);

    // Table write port; reset invalidates and clears every entry
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_vld[i] <= 1'b0;
                r_id[i]  <= '0;
                r_x[i]   <= '0;
                r_y[i]   <= '0;
                r_dir[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_vld[wr_idx] <= 1'b1;
            r_id[wr_idx]  <= wr_id;
            r_x[wr_idx]   <= wr_x;
            r_y[wr_idx]   <= wr_y;
            r_dir[wr_idx] <= wr_dir;
        end
    end

    // FSM state register; reset aborts any scan in flight
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_hit || w_last) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid    = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign busy = !req_ready;

    // Scan index, latched request ID and result registers (held between responses)
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_k       <= '0;
            r_req_id  <= '0;
            r_hit     <= 1'b0;
            r_x_out   <= '0;
            r_y_out   <= '0;
            r_dir_out <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (req_valid) begin
                    r_req_id <= req_id;
                    r_k      <= '0;
                end
            end else if (r_state == SCAN) begin
                if (w_hit) begin
                    r_hit     <= 1'b1;
                    r_x_out   <= r_x[r_k];
                    r_y_out   <= r_y[r_k];
                    r_dir_out <= r_dir[r_k];
                end else if (w_last) begin
                    r_hit     <= 1'b0;
                    r_x_out   <= '0;
                    r_y_out   <= '0;
                    r_dir_out <= '0;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    assign rsp_hit = r_hit;
    assign x_out   = r_x_out;
    assign y_out   = r_y_out;
    assign dir_out = r_dir_out;

endmodule
`default_nettype wire

// File: tb/tb_warehouse_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_warehouse_table
// Brief    : Self-checking bench for warehouse_table. Expected responses are
//            queued when a request is driven. A monitor pops each response
//            and compares it, including its latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_warehouse_table;

    localparam int N_SLOTS = 24;
    localparam int ID_W    = 6;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int DIR_W   = 12;
    localparam int IDX_W   = 5;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             req_valid;
    logic [ID_W-1:0]  req_id;
    logic             req_ready;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [ID_W-1:0]  wr_id;
    logic [X_W-1:0]   wr_x;
    logic [Y_W-1:0]   wr_y;
    logic [DIR_W-1:0] wr_dir;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [X_W-1:0]   x_out;
    logic [Y_W-1:0]   y_out;
    logic [DIR_W-1:0] dir_out;
    logic             busy;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic             hit;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [DIR_W-1:0] dir;
        int               lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    warehouse_table #(
        .N_SLOTS (N_SLOTS),
        .ID_W    (ID_W),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .DIR_W   (DIR_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_id     (wr_id),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_dir    (wr_dir),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .x_out     (x_out),
        .y_out     (y_out),
        .dir_out   (dir_out),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int id, input int hit, input int x,
                                input int y, input int dir, input int lat);
        vec_t v;
        v.id  = ID_W'(id);
        v.hit = hit[0];
        v.x   = X_W'(x);
        v.y   = Y_W'(y);
        v.dir = DIR_W'(dir);
        v.lat = lat;
        return v;
    endfunction

    // Response monitor: every rsp_valid must match the oldest queued expectation
    always @(negedge sys_clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_hit", rsp_hit, mon_e.v.hit);
                check("x_out",   x_out,   mon_e.v.x);
                check("y_out",   y_out,   mon_e.v.y);
                check("dir_out", dir_out, mon_e.v.dir);
                check("latency", cyc - mon_e.acc + 1, mon_e.v.lat);
            end
        end
    end

    // Called at a negedge; returns at a negedge
    task automatic do_write(input int idx, input int id, input int x, input int y, input int dir);
        wr_en  = 1'b1;
        wr_idx = IDX_W'(idx);
        wr_id  = ID_W'(id);
        wr_x   = X_W'(x);
        wr_y   = Y_W'(y);
        wr_dir = DIR_W'(dir);
        @(negedge sys_clk);
        wr_en  = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; hold>0 keeps req_valid high with other IDs
    task automatic lookup(input vec_t v, input int hold);
        exp_t e;
        int   n;
        e.v   = v;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        req_id    = v.id;
        req_valid = 1'b1;
        for (int i = 0; i <= hold; i++) begin
            @(negedge sys_clk);
            req_id = req_id + 1'b1;
        end
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            check("busy_during_scan", busy, 1);
            @(negedge sys_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 0, 1);
            exp_q.delete();
        end
        @(negedge sys_clk);
        check("rsp_pulse_end", rsp_valid, 0);
        check("ready_after_rsp", req_ready, 1);
    endtask

    initial begin
        vec_t vecs[5];
        int   seen;

        req_valid = 1'b0;
        req_id    = '0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_id     = '0;
        wr_x      = '0;
        wr_y      = '0;
        wr_dir    = '0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy",      busy,      0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit",   rsp_hit,   0);
        check("rst_x_out",     x_out,     0);
        check("rst_y_out",     y_out,     0);
        check("rst_dir_out",   dir_out,   0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Reset entries hold id=0 but are invalid, so id 0 must miss
        lookup(mk(0, 0, 0, 0, 0, 25), 0);

        // Single entry at idx0
        do_write(0, 1, 255, 145, 7);
        lookup(mk(1, 1, 255, 145, 7, 2), 0);

        // Fill every slot: id=i+1
        for (int i = 0; i < N_SLOTS; i++) begin
            do_write(i, i + 1, i * 10 + 3, i * 7 + 1, i * 100 + 5);
        end
        vecs[0] = mk(24, 1, 233, 162, 2305, 25);
        vecs[1] = mk(30, 0, 0, 0, 0, 25);
        vecs[2] = mk(1, 1, 3, 1, 5, 2);
        vecs[3] = mk(12, 1, 113, 78, 1105, 13);
        vecs[4] = mk(2, 1, 13, 8, 105, 3);
        for (int i = 0; i < 5; i++) begin
            lookup(vecs[i], 0);
        end

        // req_valid held through SCAN/RESP with other IDs: only one response
        lookup(mk(1, 1, 3, 1, 5, 2), 2);

        // Duplicate IDs: lowest index wins
        do_write(4, 40, 43, 29, 405);
        do_write(2, 5, 300, 200, 3000);
        do_write(7, 5, 77, 66, 555);
        lookup(mk(5, 1, 300, 200, 3000, 4), 0);
        lookup(mk(40, 1, 43, 29, 405, 6), 0);

        // Write to the entry under compare (k=6) is not seen by that compare
        fork
            lookup(mk(33, 0, 0, 0, 0, 25), 0);
            begin
                repeat (7) @(posedge sys_clk);
                @(negedge sys_clk);
                do_write(6, 33, 60, 50, 600);
            end
        join
        lookup(mk(33, 1, 60, 50, 600, 8), 0);

        // Write behind the scan (idx3 at k=5) and an out-of-range write
        fork
            lookup(mk(9, 1, 83, 57, 805, 10), 0);
            begin
                repeat (6) @(posedge sys_clk);
                @(negedge sys_clk);
                do_write(3, 9, 111, 99, 999);
                do_write(31, 50, 1, 2, 3);
            end
        join
        lookup(mk(50, 0, 0, 0, 0, 25), 0);
        lookup(mk(9, 1, 111, 99, 999, 5), 0);

        // Results hold while idle
        repeat (5) @(negedge sys_clk);
        check("hold_rsp_hit", rsp_hit, 1);
        check("hold_x_out",   x_out,   111);
        check("hold_y_out",   y_out,   99);
        check("hold_dir_out", dir_out, 999);

        // Reset mid-scan at k=10
        req_id    = 6'd50;
        req_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        req_valid = 1'b0;
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_busy",      busy,      0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_hit",   rsp_hit,   0);
        check("abort_x_out",     x_out,     0);
        check("abort_y_out",     y_out,     0);
        check("abort_dir_out",   dir_out,   0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", seen, 0);
        lookup(mk(1, 0, 0, 0, 0, 25), 0);
        lookup(mk(9, 0, 0, 0, 0, 25), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
